sq_wave_sequencer: RTL and testbench

Controller that drives a programmable square wave output through a stored list of waveform segments.
- Each segment is a (high length, low length, repeat count) entry held in a small register table.
- On start, the block plays the segments in order, optionally looping, then returns to idle.
- Sits between a host/button-config layer and the output pin. It sequences the high/low phase timing that a bare generator only applies statically.

---
 rtl/sqw_pkg.sv | 38 +++
 rtl/sqw_phase_timer.sv | 37 +++
 rtl/sq_wave_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_sq_wave_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqw_pkg.sv
// ---------------------------------------------------------------------------
// sqw_pkg
// Shared types and helpers for the square wave sequencer.
//   state_t  : sequencer FSM states (IDLE, HIGH, LOW)
//   seg_t    : one waveform table entry {hi, lo, reps}
//   norm_seg : maps zero-valued fields to 1 so counters never load 0
// SQW_W / SQW_RW / SQW_DEPTH size the table entry; the top-level parameters
// must match them.
// ---------------------------------------------------------------------------
package sqw_pkg;

    localparam int SQW_W     = 4;
    localparam int SQW_RW    = 4;
    localparam int SQW_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    typedef struct packed {
        logic [SQW_W-1:0]  hi;
        logic [SQW_W-1:0]  lo;
        logic [SQW_RW-1:0] reps;
    } seg_t;

    // A stored 0 means "one cycle" / "one period".
    function automatic seg_t norm_seg(input seg_t s);
        seg_t r;
        r = s;
        if (r.hi == '0)   r.hi   = SQW_W'(1);
        if (r.lo == '0)   r.lo   = SQW_W'(1);
        if (r.reps == '0) r.reps = SQW_RW'(1);
        return r;
    endfunction

endpackage

// File: rtl/sqw_phase_timer.sv
// ---------------------------------------------------------------------------
// sqw_phase_timer
// Loadable down-counter that times one HIGH or LOW phase.
//   clk      : system clock
//   reset    : synchronous active-high reset
//   i_load   : load i_value this edge (takes priority over counting)
//   i_value  : phase length, already normalised to >= 1
//   o_last   : high during the final cycle of the phase (count == 1)
// The count parks at 1 instead of wrapping.
// ---------------------------------------------------------------------------
module sqw_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_last
);

    logic [W-1:0] r_cnt;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt > W'(1)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_last = (r_cnt == W'(1));

endmodule

// File: rtl/sq_wave_sequencer.sv
// ---------------------------------------------------------------------------
// sq_wave_sequencer
// Plays a table of (hi, lo, reps) segments as a square wave, optionally looping.
//   clk, reset           : clock, synchronous active-high reset
//   cfg_we/addr/hi/lo/reps: table write port (accepted only while idle)
//   cfg_len, loop_en     : active entry count and loop enable, sampled on start
//   start, stop          : begin / abort (stop wins over start)
//   sq_wave              : registered square wave
//   busy, done           : running flag, one-cycle completion pulse
//   cfg_err              : one-cycle pulse after a write attempted while busy
//   cur_idx              : entry currently playing (holds in idle)
//   period_tick          : pulse per completed period (SQW_PERIOD_TICK_EN only)
// Optional feature macro: SQW_PERIOD_TICK_EN
// ---------------------------------------------------------------------------
module sq_wave_sequencer
    import sqw_pkg::*;
#(
    parameter  int W     = SQW_W,
    parameter  int RW    = SQW_RW,
    parameter  int DEPTH = SQW_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [W-1:0]  cfg_hi,
    input  logic [W-1:0]  cfg_lo,
    input  logic [RW-1:0] cfg_reps,
    input  logic [AW:0]   cfg_len,
    input  logic          loop_en,
    input  logic          start,
    input  logic          stop,
    output logic          sq_wave,
    output logic          busy,
    output logic          done,
    output logic          cfg_err,
    output logic [AW-1:0] cur_idx
`ifdef SQW_PERIOD_TICK_EN
    ,
    output logic          period_tick
`endif
);

    // Table entries are package-typed, so the widths must agree.
    if (W != SQW_W || RW != SQW_RW || DEPTH != SQW_DEPTH) begin : g_param_check
        $error("sq_wave_sequencer parameters must match sqw_pkg widths");
    end

    localparam logic [AW:0] LEN_ONE   = (AW+1)'(1);
    localparam logic [AW:0] LEN_DEPTH = (AW+1)'(DEPTH);

    seg_t          r_tab [DEPTH];
    state_t        r_state, w_next_state;
    logic [AW-1:0] r_idx, w_next_idx;
    logic [RW-1:0] r_rep, w_next_rep;
    logic [AW:0]   r_len, w_len_norm;
    logic          r_loop;
    logic          r_sq, r_busy, r_done, r_cfg_err;
    logic          w_load, w_last, w_done, w_more_entries, w_start_ok;
    logic [W-1:0]  w_load_val;
    seg_t          w_cur, w_next_seg, w_first;

    assign w_cur      = norm_seg(r_tab[r_idx]);
    assign w_first    = norm_seg(r_tab[0]);
    // Only used when idx+1 < len <= DEPTH, so the index never wraps in use.
    assign w_next_seg = norm_seg(r_tab[r_idx + AW'(1)]);

    assign w_more_entries = ({1'b0, r_idx} + LEN_ONE) < r_len;
    assign w_start_ok     = (r_state == IDLE) && start && !stop;

    always_comb begin
        w_len_norm = cfg_len;
        if (cfg_len == '0)           w_len_norm = LEN_ONE;
        else if (cfg_len > LEN_DEPTH) w_len_norm = LEN_DEPTH;
    end

    sqw_phase_timer #(.W(W)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_value (w_load_val),
        .o_last  (w_last)
    );

    // NOTE: every always_comb output gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_next_rep   = r_rep;
        w_load       = 1'b0;
        w_load_val   = '0;
        w_done       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_next_state = HIGH;
                    w_next_idx   = '0;
                    w_next_rep   = w_first.reps;
                    w_load       = 1'b1;
                    w_load_val   = w_first.hi;
                end
            end
            HIGH: begin
                if (stop) begin
                    w_next_state = IDLE;
                end else if (w_last) begin
                    w_next_state = LOW;
                    w_load       = 1'b1;
                    w_load_val   = w_cur.lo;
                end
            end
            LOW: begin
                if (stop) begin
                    w_next_state = IDLE;
                end else if (w_last) begin
                    w_next_state = HIGH;
                    w_load       = 1'b1;
                    if (r_rep > RW'(1)) begin
                        w_next_rep = r_rep - RW'(1);
                        w_load_val = w_cur.hi;
                    end else if (w_more_entries) begin
                        w_next_idx = r_idx + AW'(1);
                        w_next_rep = w_next_seg.reps;
                        w_load_val = w_next_seg.hi;
                    end else if (r_loop) begin
                        w_next_idx = '0;
                        w_next_rep = w_first.reps;
                        w_load_val = w_first.hi;
                    end else begin
                        w_next_state = IDLE;
                        w_load       = 1'b0;
                        w_done       = 1'b1;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_rep     <= '0;
            r_len     <= '0;
            r_loop    <= 1'b0;
            r_sq      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            // NOTE: the table is a small register file that must read back as
            // zero after reset, so it is cleared here rather than left to a RAM.
            for (int i = 0; i < DEPTH; i++) r_tab[i] <= '0;
        end else begin
            r_state   <= w_next_state;
            r_idx     <= w_next_idx;
            r_rep     <= w_next_rep;
            r_sq      <= (w_next_state == HIGH);
            r_busy    <= (w_next_state != IDLE);
            r_done    <= w_done;
            r_cfg_err <= cfg_we && (r_state != IDLE);
            if (w_start_ok) begin
                r_len  <= w_len_norm;
                r_loop <= loop_en;
            end
            if (cfg_we && r_state == IDLE) begin
                r_tab[cfg_addr] <= '{hi: cfg_hi, lo: cfg_lo, reps: cfg_reps};
            end
        end
    end

    assign sq_wave = r_sq;
    assign busy    = r_busy;
    assign done    = r_done;
    assign cfg_err = r_cfg_err;
    assign cur_idx = r_idx;

`ifdef SQW_PERIOD_TICK_EN
    logic w_tick;
    logic r_tick;

    // A period completes on the edge leaving its last LOW cycle.
    assign w_tick = (r_state == LOW) && w_last && !stop;

    always_ff @(posedge clk) begin
        if (reset) r_tick <= 1'b0;
        else       r_tick <= w_tick;
    end

    assign period_tick = r_tick;
`endif

endmodule

// File: tb/tb_sq_wave_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sq_wave_sequencer
// Directed scenarios with literal expectations plus a randomized phase, all
// checked every cycle against a queue-based model of the expected waveform.
// ---------------------------------------------------------------------------
module tb_sq_wave_sequencer;

    localparam int W     = 4;
    localparam int RW    = 4;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic          clk;
    logic          reset;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [W-1:0]  cfg_hi;
    logic [W-1:0]  cfg_lo;
    logic [RW-1:0] cfg_reps;
    logic [AW:0]   cfg_len;
    logic          loop_en;
    logic          start;
    logic          stop;
    logic          sq_wave;
    logic          busy;
    logic          done;
    logic          cfg_err;
    logic [AW-1:0] cur_idx;
    logic          period_tick;

    sq_wave_sequencer #(.W(W), .RW(RW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_hi   (cfg_hi),
        .cfg_lo   (cfg_lo),
        .cfg_reps (cfg_reps),
        .cfg_len  (cfg_len),
        .loop_en  (loop_en),
        .start    (start),
        .stop     (stop),
        .sq_wave  (sq_wave),
        .busy     (busy),
        .done     (done),
        .cfg_err  (cfg_err),
        .cur_idx  (cur_idx)
`ifdef SQW_PERIOD_TICK_EN
        ,
        .period_tick (period_tick)
`endif
    );

`ifndef SQW_PERIOD_TICK_EN
    assign period_tick = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each running cycle is one queue element; a pass over the table is
    // expanded up front from the segment rules.
    typedef struct {
        bit sq;
        int idx;
        bit period_end;
    } cyc_t;

    cyc_t q[$];
    int   m_hi   [DEPTH];
    int   m_lo   [DEPTH];
    int   m_reps [DEPTH];
    int   m_len;
    bit   m_loop;
    bit   running;
    bit   model_valid = 0;
    bit   e_sq, e_busy, e_done, e_err, e_tick;
    int   e_idx;

    function automatic int nz(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic build_pass();
        for (int e = 0; e < m_len; e++)
            for (int r = 0; r < nz(m_reps[e]); r++) begin
                for (int h = 0; h < nz(m_hi[e]); h++) q.push_back('{1'b1, e, 1'b0});
                for (int l = 0; l < nz(m_lo[e]); l++) q.push_back('{1'b0, e, (l == nz(m_lo[e]) - 1)});
            end
    endtask

    always @(posedge clk) begin
        cyc_t cur;
        bit   was_run;
        was_run = running;
        e_done  = 0;
        e_err   = 0;
        e_tick  = 0;
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_hi[i] = 0; m_lo[i] = 0; m_reps[i] = 0;
            end
            q.delete();
            running     = 0;
            e_idx       = 0;
            model_valid = 1;
        end else begin
            if (was_run) begin
                if (cfg_we) e_err = 1;
                if (stop) begin
                    running = 0;
                    q.delete();
                end else begin
                    cur = q.pop_front();
                    if (cur.period_end) e_tick = 1;
                    if (q.size() == 0) begin
                        if (m_loop) build_pass();
                        else begin
                            running = 0;
                            e_done  = 1;
                        end
                    end
                end
            end else begin
                if (start && !stop) begin
                    m_len   = (cfg_len == 0) ? 1 : ((int'(cfg_len) > DEPTH) ? DEPTH : int'(cfg_len));
                    m_loop  = loop_en;
                    build_pass();
                    running = 1;
                end
                if (cfg_we) begin
                    m_hi[cfg_addr]   = int'(cfg_hi);
                    m_lo[cfg_addr]   = int'(cfg_lo);
                    m_reps[cfg_addr] = int'(cfg_reps);
                end
            end
            if (running) e_idx = q[0].idx;
        end
        e_sq   = running ? q[0].sq : 1'b0;
        e_busy = running;
    end

    // Compare process: outputs change only at posedge, so negedge is stable.
    always @(negedge clk) begin
        if (model_valid) begin
            check("sq_wave", sq_wave, e_sq);
            check("busy", busy, e_busy);
            check("done", done, e_done);
            check("cfg_err", cfg_err, e_err);
            check("cur_idx", cur_idx, e_idx);
`ifdef SQW_PERIOD_TICK_EN
            check("period_tick", period_tick, e_tick);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic write_entry(input int a, input int hi, input int lo, input int reps);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = AW'(a);
        cfg_hi   = W'(hi);
        cfg_lo   = W'(lo);
        cfg_reps = RW'(reps);
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    // Returns at the negedge right after the edge that accepted start.
    task automatic start_seq(input int len, input bit lp);
        @(negedge clk);
        cfg_len = (AW+1)'(len);
        loop_en = lp;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [9:0] pat;
    logic [9:0] tk;
    int         idx_at3;
    int         n;

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_hi = '0; cfg_lo = '0;
        cfg_reps = '0; cfg_len = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_sq", sq_wave, 0);
        check("reset_busy", busy, 0);
        check("reset_idx", cur_idx, 0);
        reset = 1'b0;

        // Scenario 1: 3/2 x2, single entry
        write_entry(0, 3, 2, 2);
        start_seq(1, 0);
        pat = '0; tk = '0;
        for (int i = 0; i < 10; i++) begin
            pat = {pat[8:0], sq_wave};
            tk  = {tk[8:0], period_tick};
            @(negedge clk);
        end
        check("s1_pattern", pat, 10'b1110011100);
        check("s1_done", done, 1);
        check("s1_busy_drop", busy, 0);
`ifdef SQW_PERIOD_TICK_EN
        check("s6_tick_mid", tk, 10'b0000010000);
        check("s6_tick_end", period_tick, 1);
`endif

        // Scenario 2: two entries
        write_entry(0, 1, 1, 1);
        write_entry(1, 2, 4, 1);
        start_seq(2, 0);
        pat = '0; idx_at3 = -1;
        for (int i = 0; i < 8; i++) begin
            pat = {pat[8:0], sq_wave};
            if (i == 2) idx_at3 = int'(cur_idx);
            @(negedge clk);
        end
        check("s2_pattern", pat[7:0], 8'b10110000);
        check("s2_idx_third", idx_at3, 1);
        check("s2_done", done, 1);

        // Scenario 3/4: zero fields normalise, loop, write while busy, stop
        write_entry(0, 0, 0, 0);
        start_seq(1, 1);
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            pat = {pat[8:0], sq_wave};
            @(negedge clk);
        end
        check("s3_loop_pattern", pat[5:0], 6'b101010);
        cfg_we = 1'b1; cfg_addr = '0; cfg_hi = 4'd7; cfg_lo = 4'd7; cfg_reps = 4'd7;
        @(negedge clk);
        cfg_we = 1'b0;
        check("s4_cfg_err_pulse", cfg_err, 1);
        @(negedge clk);
        check("s4_cfg_err_once", cfg_err, 0);
        repeat (5) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("s3_stop_sq", sq_wave, 0);
        check("s3_stop_busy", busy, 0);
        check("s3_stop_no_done", done, 0);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("s4_start_stop_idle", busy, 0);

        // Scenario 5: cfg_len clamping
        for (int a = 0; a < DEPTH; a++) write_entry(a, 1, 1, 1);
        start_seq(0, 0);
        count_busy(n);
        check("s5_len0_cycles", n, 2);
        start_seq(DEPTH + 3, 0);
        count_busy(n);
        check("s5_len_clamp_cycles", n, 2 * DEPTH);

        // Reset mid-HIGH clears outputs and table
        write_entry(0, 5, 5, 1);
        start_seq(1, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("s5_rst_sq", sq_wave, 0);
        check("s5_rst_busy", busy, 0);
        check("s5_rst_done", done, 0);
        start_seq(1, 0);
        check("s5_cleared_hi", sq_wave, 1);
        @(negedge clk);
        check("s5_cleared_lo", sq_wave, 0);
        @(negedge clk);
        check("s5_cleared_done", done, 1);

        // Randomized phase, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start    = ($urandom_range(0, 7) == 0);
            cfg_len  = (AW+1)'($urandom_range(0, 7));
            loop_en  = ($urandom_range(0, 3) == 0);
            stop     = ($urandom_range(0, 49) == 0);
            cfg_we   = !start && ($urandom_range(0, 5) == 0);
            cfg_addr = AW'($urandom_range(0, DEPTH - 1));
            cfg_hi   = W'($urandom_range(0, 4));
            cfg_lo   = W'($urandom_range(0, 4));
            cfg_reps = RW'($urandom_range(0, 2));
            reset    = ($urandom_range(0, 599) == 0);
        end
        @(negedge clk);
        start = 1'b0; stop = 1'b1; cfg_we = 1'b0; reset = 1'b0;
        @(negedge clk);
        stop = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
